alu_exec_stage: RTL and testbench

Execute-stage sequencer that sits directly upstream of the combinational ALU in the filter processor pipeline.
- Accepts decoded instructions over a valid/ready handshake.
- Holds opcode and operands stable on the ALU inputs for one cycle, or MUL_CYCLES cycles for multiply.
- Captures the ALU result into an output register toward writeback, with a valid/ready handshake.
- Maintains the architectural compare flag used by conditional branches.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_exec_if.sv | 29 ++
 rtl/alu_exec_stage.sv | 107 ++++++++++
 tb/tb_alu_exec_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode map, opcode class helpers and execute-stage state encoding.
package alu_pkg;

  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_SUB    = 6'b000001;
  localparam logic [5:0] OP_MUL    = 6'b000010;
  localparam logic [5:0] OP_AND    = 6'b000011;
  localparam logic [5:0] OP_OR     = 6'b000100;
  localparam logic [5:0] OP_XOR    = 6'b000101;
  localparam logic [5:0] OP_NOT    = 6'b000110;
  localparam logic [5:0] OP_SLL    = 6'b000111;
  localparam logic [5:0] OP_SRA    = 6'b001000;
  localparam logic [5:0] OP_SRL    = 6'b001001;
  localparam logic [5:0] OP_CMP_LE = 6'b111010;
  localparam logic [5:0] OP_CMP_EQ = 6'b101011;
  localparam logic [5:0] OP_CMP_LT = 6'b011011;
  localparam logic [5:0] OP_NOP    = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FULL = 2'd2
  } exec_state_t;

  function automatic logic is_writing(input logic [5:0] op);
    return op <= OP_SRL;
  endfunction

  function automatic logic is_compare(input logic [5:0] op);
    return (op == OP_CMP_LE) || (op == OP_CMP_EQ) || (op == OP_CMP_LT);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Instruction-in and result-out handshakes of the ALU execute stage.
interface alu_exec_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int RD_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic [RD_W-1:0]   in_rd;
  logic              in_wb_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_z;
  logic [RD_W-1:0]   out_rd;
  logic              out_wb_en;

  // master: decode/writeback side; slave: the execute stage
  modport master (
    output in_valid, in_op, in_x, in_y, in_rd, in_wb_en, out_ready,
    input  in_ready, out_valid, out_z, out_rd, out_wb_en
  );
  modport slave (
    input  in_valid, in_op, in_x, in_y, in_rd, in_wb_en, out_ready,
    output in_ready, out_valid, out_z, out_rd, out_wb_en
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer: holds operands on the external ALU, waits out multiply
// latency, registers the result toward writeback and owns the compare flag.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 6,
  parameter int RD_W       = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_exec_if.slave         bus,
  output logic [OP_W-1:0]   alu_code,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_cmp,
  output logic              cmp_flag,
  output logic              busy
);

  localparam logic [3:0]      MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [OP_W-1:0] NOP_CODE = OP_W'(OP_NOP);

  exec_state_t     state_reg, state_next;
  logic [3:0]      cnt_reg;
  logic [RD_W-1:0] rd_reg;
  logic            wb_en_reg;
  logic            accept;
  logic            capture;

  assign accept  = bus.in_valid && bus.in_ready;
  assign capture = (state_reg == ST_EXEC) && (cnt_reg == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) state_next = ST_EXEC;
        ST_EXEC: if (cnt_reg == 4'd0) state_next = ST_FULL;
        ST_FULL: if (bus.out_ready) state_next = accept ? ST_EXEC : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = !flush && ((state_reg == ST_IDLE) ||
                              ((state_reg == ST_FULL) && bus.out_ready));
    busy         = (state_reg != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_code      <= NOP_CODE;
      alu_x         <= '0;
      alu_y         <= '0;
      cnt_reg       <= 4'd0;
      rd_reg        <= '0;
      wb_en_reg     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_z     <= '0;
      bus.out_rd    <= '0;
      bus.out_wb_en <= 1'b0;
      cmp_flag      <= 1'b0;
    end else if (flush) begin
      // cmp_flag survives a flush: it is architectural, not in-flight state
      alu_code      <= NOP_CODE;
      alu_x         <= '0;
      alu_y         <= '0;
      cnt_reg       <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.out_wb_en <= 1'b0;
    end else begin
      if (accept) begin
        alu_code  <= bus.in_op;
        alu_x     <= bus.in_x;
        alu_y     <= bus.in_y;
        rd_reg    <= bus.in_rd;
        wb_en_reg <= bus.in_wb_en;
        cnt_reg   <= (bus.in_op == OP_MUL) ? MUL_LOAD : 4'd0;
      end else if ((state_reg == ST_EXEC) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (capture) begin
        bus.out_valid <= 1'b1;
        bus.out_z     <= alu_z;
        bus.out_rd    <= rd_reg;
        bus.out_wb_en <= wb_en_reg && is_writing(alu_code);
        if (is_compare(alu_code)) cmp_flag <= alu_cmp;
      end else if ((state_reg == ST_FULL) && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with a small behavioural ALU beside each DUT.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  alu_code3, alu_code1;
  logic [31:0] alu_x3, alu_y3, alu_z3, alu_x1, alu_y1, alu_z1;
  logic        alu_cmp3, alu_cmp1, cmp_flag3, cmp_flag1, busy3, busy1;
  int          checks = 0;
  int          errors = 0;

  alu_exec_if #(.DATA_W(32), .OP_W(6), .RD_W(4)) b3 ();
  alu_exec_if #(.DATA_W(32), .OP_W(6), .RD_W(4)) b1 ();

  alu_exec_stage #(.DATA_W(32), .OP_W(6), .RD_W(4), .MUL_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b3),
    .alu_code(alu_code3), .alu_x(alu_x3), .alu_y(alu_y3), .alu_z(alu_z3),
    .alu_cmp(alu_cmp3), .cmp_flag(cmp_flag3), .busy(busy3));

  alu_exec_stage #(.DATA_W(32), .OP_W(6), .RD_W(4), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b1),
    .alu_code(alu_code1), .alu_x(alu_x1), .alu_y(alu_y1), .alu_z(alu_z1),
    .alu_cmp(alu_cmp1), .cmp_flag(cmp_flag1), .busy(busy1));

  always #5 clk = ~clk;

  // Non-compare codes drive CMP high so any stray sampling of it is visible.
  function automatic logic [32:0] alu_model(input logic [5:0] code, input logic [31:0] x, input logic [31:0] y);
    case (code)
      OP_ADD:    return {1'b1, x + y};
      OP_SUB:    return {1'b1, x - y};
      OP_MUL:    return {1'b1, x * y};
      OP_CMP_LE: return {(x <= y), 32'd0};
      OP_CMP_EQ: return {(x == y), 32'd0};
      OP_CMP_LT: return {(x < y), 32'd0};
      default:   return {1'b1, 32'd0};
    endcase
  endfunction

  assign {alu_cmp3, alu_z3} = alu_model(alu_code3, alu_x3, alu_y3);
  assign {alu_cmp1, alu_z1} = alu_model(alu_code1, alu_x1, alu_y1);

  task automatic send3(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] rd, input logic wb);
    b3.in_valid = 1'b1; b3.in_op = op; b3.in_x = x; b3.in_y = y; b3.in_rd = rd; b3.in_wb_en = wb;
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", b3.out_valid); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy3); end
    checks++; if (alu_code3 !== 6'h3f) begin errors++; $display("FAIL reset_alu_code got %0h exp 3f", alu_code3); end
    checks++; if (cmp_flag3 !== 1'b0 || b3.out_z !== 32'd0 || alu_x3 !== 32'd0) begin errors++; $display("FAIL reset_regs got cmp=%0b z=%0h x=%0h exp 0/0/0", cmp_flag3, b3.out_z, alu_x3); end
    checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", b3.in_ready); end
  endtask

  task automatic test_add();
    b3.out_ready = 1'b1;
    send3(OP_ADD, 32'd7, 32'd5, 4'd3, 1'b1);
    checks++; if (busy3 !== 1'b1 || b3.out_valid !== 1'b0) begin errors++; $display("FAIL add_exec got busy=%0b valid=%0b exp 1/0", busy3, b3.out_valid); end
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", b3.out_valid); end
    checks++; if (b3.out_z !== 32'd12 || b3.out_rd !== 4'd3 || b3.out_wb_en !== 1'b1) begin errors++; $display("FAIL add_result got z=%0d rd=%0d wb=%0b exp 12/3/1", b3.out_z, b3.out_rd, b3.out_wb_en); end
    checks++; if (cmp_flag3 !== 1'b0) begin errors++; $display("FAIL add_cmp got %0b exp 0", cmp_flag3); end
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL add_idle got valid=%0b busy=%0b exp 0/0", b3.out_valid, busy3); end
  endtask

  task automatic test_mul();
    send3(OP_MUL, 32'd6, 32'd7, 4'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (b3.in_ready !== 1'b0 || b3.out_valid !== 1'b0 || alu_x3 !== 32'd6 || alu_y3 !== 32'd7) begin
        errors++; $display("FAIL mul3_hold[%0d] got rdy=%0b vld=%0b x=%0d y=%0d exp 0/0/6/7", i, b3.in_ready, b3.out_valid, alu_x3, alu_y3); end
      @(posedge clk); #1;
    end
    checks++; if (b3.out_valid !== 1'b1 || b3.out_z !== 32'd42) begin errors++; $display("FAIL mul3_result got vld=%0b z=%0d exp 1/42", b3.out_valid, b3.out_z); end
    @(posedge clk); #1;
    b1.out_ready = 1'b1; b1.in_valid = 1'b1; b1.in_op = OP_MUL; b1.in_x = 32'd6; b1.in_y = 32'd7; b1.in_rd = 4'd1; b1.in_wb_en = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL mul1_early got %0b exp 0", b1.out_valid); end
    @(posedge clk); #1;
    checks++; if (b1.out_valid !== 1'b1 || b1.out_z !== 32'd42) begin errors++; $display("FAIL mul1_result got vld=%0b z=%0d exp 1/42", b1.out_valid, b1.out_z); end
    @(posedge clk); #1;
  endtask

  task automatic test_compare();
    send3(OP_CMP_LT, 32'd2, 32'd9, 4'd4, 1'b1);
    @(posedge clk); #1;
    checks++; if (cmp_flag3 !== 1'b1 || b3.out_wb_en !== 1'b0 || b3.out_z !== 32'd0) begin errors++; $display("FAIL cmp_lt got cmp=%0b wb=%0b z=%0d exp 1/0/0", cmp_flag3, b3.out_wb_en, b3.out_z); end
    @(posedge clk); #1;
    send3(OP_CMP_EQ, 32'd4, 32'd5, 4'd4, 1'b1);
    @(posedge clk); #1;
    checks++; if (cmp_flag3 !== 1'b0) begin errors++; $display("FAIL cmp_eq got %0b exp 0", cmp_flag3); end
    @(posedge clk); #1;
    send3(OP_ADD, 32'd1, 32'd1, 4'd6, 1'b1);
    @(posedge clk); #1;
    checks++; if (cmp_flag3 !== 1'b0 || b3.out_z !== 32'd2) begin errors++; $display("FAIL cmp_add_keep got cmp=%0b z=%0d exp 0/2", cmp_flag3, b3.out_z); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    b3.out_ready = 1'b0;
    send3(OP_SUB, 32'd10, 32'd4, 4'd5, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (b3.out_valid !== 1'b1 || b3.out_z !== 32'd6 || b3.out_rd !== 4'd5 || b3.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got vld=%0b z=%0d rd=%0d rdy=%0b exp 1/6/5/0", i, b3.out_valid, b3.out_z, b3.out_rd, b3.in_ready); end
      @(posedge clk); #1;
    end
    b3.out_ready = 1'b1;
    b3.in_valid = 1'b1; b3.in_op = OP_ADD; b3.in_x = 32'd2; b3.in_y = 32'd3; b3.in_rd = 4'd1; b3.in_wb_en = 1'b1;
    #1;
    checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %0b exp 1", b3.in_ready); end
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
    checks++; if (b3.out_valid !== 1'b0 || busy3 !== 1'b1 || alu_x3 !== 32'd2) begin errors++; $display("FAIL bp_swap got vld=%0b busy=%0b x=%0d exp 0/1/2", b3.out_valid, busy3, alu_x3); end
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b1 || b3.out_z !== 32'd5 || b3.out_rd !== 4'd1) begin errors++; $display("FAIL bp_second got vld=%0b z=%0d rd=%0d exp 1/5/1", b3.out_valid, b3.out_z, b3.out_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    send3(OP_CMP_LT, 32'd1, 32'd2, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send3(OP_MUL, 32'd3, 32'd3, 4'd7, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    b3.in_valid = 1'b1; b3.in_op = OP_ADD; b3.in_x = 32'd8; b3.in_y = 32'd8; b3.in_rd = 4'd2; b3.in_wb_en = 1'b1;
    #1;
    checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", b3.in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; b3.in_valid = 1'b0;
    checks++; if (busy3 !== 1'b0 || b3.out_valid !== 1'b0 || alu_code3 !== 6'h3f || alu_x3 !== 32'd0) begin
      errors++; $display("FAIL flush_idle got busy=%0b vld=%0b code=%0h x=%0d exp 0/0/3f/0", busy3, b3.out_valid, alu_code3, alu_x3); end
    checks++; if (cmp_flag3 !== 1'b1) begin errors++; $display("FAIL flush_cmp got %0b exp 1", cmp_flag3); end
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL flush_late got vld=%0b busy=%0b exp 0/0", b3.out_valid, busy3); end
  endtask

  task automatic test_nop();
    send3(OP_CMP_EQ, 32'd4, 32'd5, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send3(6'b110000, 32'd9, 32'd9, 4'd8, 1'b1);
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b1 || b3.out_wb_en !== 1'b0 || b3.out_rd !== 4'd8) begin errors++; $display("FAIL nop_beat got vld=%0b wb=%0b rd=%0d exp 1/0/8", b3.out_valid, b3.out_wb_en, b3.out_rd); end
    checks++; if (cmp_flag3 !== 1'b0) begin errors++; $display("FAIL nop_cmp got %0b exp 0", cmp_flag3); end
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL nop_single got %0b exp 0", b3.out_valid); end
  endtask

  task automatic test_async_reset();
    send3(OP_CMP_LT, 32'd1, 32'd2, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    b3.out_ready = 1'b0;
    send3(OP_ADD, 32'd1, 32'd1, 4'd2, 1'b1);
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b1 || cmp_flag3 !== 1'b1) begin errors++; $display("FAIL arst_pre got vld=%0b cmp=%0b exp 1/1", b3.out_valid, cmp_flag3); end
    #2 rst = 1'b1;
    #1;
    checks++; if (b3.out_valid !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL arst_drop got vld=%0b busy=%0b exp 0/0", b3.out_valid, busy3); end
    checks++; if (alu_code3 !== 6'h3f || cmp_flag3 !== 1'b0 || b3.out_z !== 32'd0) begin errors++; $display("FAIL arst_regs got code=%0h cmp=%0b z=%0d exp 3f/0/0", alu_code3, cmp_flag3, b3.out_z); end
    @(posedge clk); #1;
    rst = 1'b0; b3.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (b3.out_valid !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL arst_after got vld=%0b busy=%0b exp 0/0", b3.out_valid, busy3); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    b3.in_valid = 1'b0; b3.in_op = OP_NOP; b3.in_x = '0; b3.in_y = '0; b3.in_rd = '0; b3.in_wb_en = 1'b0; b3.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_op = OP_NOP; b1.in_x = '0; b1.in_y = '0; b1.in_rd = '0; b1.in_wb_en = 1'b0; b1.out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_add();
    test_mul();
    test_compare();
    test_back_to_back();
    test_flush();
    test_nop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
